// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the RV32I memory stage: access-size encodings,
// memory-stage FSM states and small decode helpers for funct3.
package pipeline_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dmctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } memstate_e;

    // Any encoding with bit 1 set (010, 011, 110, 111) behaves as a word access.
    function automatic logic is_word(input logic [2:0] ctrl);
        return ctrl[1];
    endfunction

    function automatic logic is_half(input logic [2:0] ctrl);
        return ~ctrl[1] & ctrl[0];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment check, store lane replication and
// byte enables, and load byte/half extraction with sign or zero extension.
module lsu_align
    import pipeline_pkg::*;
(
    input  logic [2:0]      ctrl,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] store_data,
    input  logic [2:0]      ld_ctrl,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] rdata,
    output logic            mis,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        mis   = 1'b0;
        be    = 4'b1111;
        wdata = store_data;
        if (is_word(ctrl)) begin
            mis = (off != 2'b00);
        end else if (is_half(ctrl)) begin
            mis   = off[0];
            be    = 4'b0011 << off;
            wdata = {2{store_data[15:0]}};
        end else begin
            be    = 4'b0001 << off;
            wdata = {4{store_data[7:0]}};
        end
    end

    assign shifted = rdata >> {ld_off, 3'b000};

    // ld_ctrl[2] marks the unsigned variants (BU/HU) for sub-word loads.
    always_comb begin
        ld_data = shifted;
        if (is_half(ld_ctrl)) begin
            ld_data = ld_ctrl[2] ? {16'h0000, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
        end else if (!is_word(ld_ctrl)) begin
            ld_data = ld_ctrl[2] ? {24'h000000, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
        end
    end

endmodule

// File: rtl/memaccess_stage.sv
// RV32I memory stage: issues loads/stores over a req/gnt/rvalid bus, stalls
// the pipeline while an access is outstanding and registers the load result.
module memaccess_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] ALURes_input,
    input  logic [XLEN-1:0] rs2Data_input,
    input  logic            DMWr_input,
    input  logic            DMRd_input,
    input  logic [2:0]      DMCtrl_input,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] DMDataRd_output,
    output logic            stall,
    output logic            misaligned
);

    memstate_e       state_reg, state_next;
    logic [1:0]      off_reg;
    logic [2:0]      ctrl_reg;
    logic            is_load_reg;

    logic            access;
    logic            mis_raw;
    logic            issue;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_data;

    lsu_align u_align (
        .ctrl       (DMCtrl_input),
        .off        (ALURes_input[1:0]),
        .store_data (rs2Data_input),
        .ld_ctrl    (ctrl_reg),
        .ld_off     (off_reg),
        .rdata      (mem_rdata),
        .mis        (mis_raw),
        .be         (st_be),
        .wdata      (st_wdata),
        .ld_data    (ld_data)
    );

    assign access = DMWr_input | DMRd_input;
    assign issue  = (state_reg == IDLE) & access & ~mis_raw;

    // Gated by rst_n so both flags read 0 while reset is held.
    assign stall      = rst_n & (issue | (state_reg == REQ) | (state_reg == WAIT));
    assign misaligned = rst_n & (state_reg == IDLE) & access & mis_raw;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (issue)      state_next = REQ;
            REQ:  if (mem_gnt)    state_next = WAIT;
            WAIT: if (mem_rvalid) state_next = DONE;
            DONE:                 state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_be          <= 4'b0000;
            DMDataRd_output <= '0;
            off_reg         <= 2'b00;
            ctrl_reg        <= 3'b000;
            is_load_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (issue) begin
                // A store wins when both requests are raised.
                mem_req     <= 1'b1;
                mem_we      <= DMWr_input;
                mem_addr    <= {ALURes_input[XLEN-1:2], 2'b00};
                mem_wdata   <= DMWr_input ? st_wdata : '0;
                mem_be      <= DMWr_input ? st_be : 4'b1111;
                off_reg     <= ALURes_input[1:0];
                ctrl_reg    <= DMCtrl_input;
                is_load_reg <= ~DMWr_input;
            end
            if ((state_reg == REQ) && mem_gnt) begin
                mem_req <= 1'b0;
            end
            if ((state_reg == WAIT) && mem_rvalid && is_load_reg) begin
                DMDataRd_output <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_memaccess_stage.sv
// Directed bench for memaccess_stage: loads, stores, misalignment, mid-access
// reset and store-over-load priority, with hand-computed expectations.
module tb_memaccess_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALURes_input;
    logic [31:0] rs2Data_input;
    logic        DMWr_input;
    logic        DMRd_input;
    logic [2:0]  DMCtrl_input;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] DMDataRd_output;
    logic        stall;
    logic        misaligned;

    int total = 0;
    int bad   = 0;
    int stalls;

    memaccess_stage #(.XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ALURes_input    (ALURes_input),
        .rs2Data_input   (rs2Data_input),
        .DMWr_input      (DMWr_input),
        .DMRd_input      (DMRd_input),
        .DMCtrl_input    (DMCtrl_input),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .DMDataRd_output (DMDataRd_output),
        .stall           (stall),
        .misaligned      (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Count this cycle's stall, then move to 1 time unit after the next edge.
    task automatic tick(inout int s);
        if (stall === 1'b1) s++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        DMWr_input    = 1'b0;
        DMRd_input    = 1'b0;
        DMCtrl_input  = 3'b000;
        ALURes_input  = 32'h0;
        rs2Data_input = 32'h0;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] rs2);
        DMWr_input    = wr;
        DMRd_input    = rd;
        DMCtrl_input  = ctrl;
        ALURes_input  = addr;
        rs2Data_input = rs2;
        #1;
    endtask

    // Walks one access from its IDLE cycle through DONE and back to IDLE.
    task automatic do_access(input int gnt_dly, input logic [31:0] rdata, output int s);
        s = 0;
        chk("c0_stall", {31'b0, stall}, 32'd1);
        chk("c0_misalign", {31'b0, misaligned}, 32'd0);
        tick(s);
        for (int i = 0; i < gnt_dly; i++) begin
            chk("req_hold", {31'b0, mem_req}, 32'd1);
            tick(s);
        end
        chk("req_hold", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        tick(s);
        mem_gnt = 1'b0;
        chk("wait_req_low", {31'b0, mem_req}, 32'd0);
        chk("wait_stall", {31'b0, stall}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick(s);
        mem_rvalid = 1'b0;
        chk("done_stall", {31'b0, stall}, 32'd0);
        clear_inputs();
        tick(s);
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_rd", DMDataRd_output, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle pipeline with no memory op: no stall.
        chk("nop_stall", {31'b0, stall}, 32'd0);

        // LB at 0x1003, immediate gnt/rvalid.
        drive(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0);
        do_access(0, 32'h80FF_1234, stalls);
        chk("lb_data", DMDataRd_output, 32'hFFFF_FF80);
        chk("lb_stalls", stalls, 32'd3);
        chk("lb_addr", mem_addr, 32'h0000_1000);
        chk("lb_be", {28'b0, mem_be}, 32'hF);
        chk("lb_we", {31'b0, mem_we}, 32'd0);

        // LHU at 0x2002, gnt two cycles late.
        drive(1'b0, 1'b1, 3'b101, 32'h0000_2002, 32'h0);
        do_access(2, 32'hBEEF_0000, stalls);
        chk("lhu_data", DMDataRd_output, 32'h0000_BEEF);
        chk("lhu_stalls", stalls, 32'd5);
        chk("lhu_addr", mem_addr, 32'h0000_2000);

        // SB at 0x11.
        drive(1'b1, 1'b0, 3'b000, 32'h0000_0011, 32'h1234_56AB);
        do_access(0, 32'hFFFF_FFFF, stalls);
        chk("sb_be", {28'b0, mem_be}, 32'h2);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb_addr", mem_addr, 32'h0000_0010);
        chk("sb_we", {31'b0, mem_we}, 32'd1);
        chk("sb_rd_keep", DMDataRd_output, 32'h0000_BEEF);

        // SH at 0x22 lands in the upper half-word.
        drive(1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'h0000_A1B2);
        do_access(1, 32'h0, stalls);
        chk("sh_be", {28'b0, mem_be}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'hA1B2_A1B2);
        chk("sh_stalls", stalls, 32'd4);

        // Misaligned LW at 0x6.
        drive(1'b0, 1'b1, 3'b010, 32'h0000_0006, 32'h0);
        chk("mis_flag", {31'b0, misaligned}, 32'd1);
        chk("mis_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        clear_inputs();
        #1;
        chk("mis_req", {31'b0, mem_req}, 32'd0);
        chk("mis_flag_off", {31'b0, misaligned}, 32'd0);
        @(posedge clk);
        #1;
        chk("mis_req2", {31'b0, mem_req}, 32'd0);
        chk("mis_rd_keep", DMDataRd_output, 32'h0000_BEEF);

        // Misaligned LH at odd address.
        drive(1'b0, 1'b1, 3'b001, 32'h0000_0031, 32'h0);
        chk("mis_lh", {31'b0, misaligned}, 32'd1);
        clear_inputs();
        #1;

        // LW at 0x8, reset asserted while in WAIT.
        drive(1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'h0);
        @(posedge clk);
        #1;
        mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        chk("pre_rst_stall", {31'b0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, mem_req}, 32'd0);
        chk("arst_stall", {31'b0, stall}, 32'd0);
        chk("arst_rd", DMDataRd_output, 32'h0);
        chk("arst_addr", mem_addr, 32'h0);
        clear_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        chk("post_rst_rd", DMDataRd_output, 32'h0);
        chk("post_rst_stall", {31'b0, stall}, 32'd0);
        chk("post_rst_req", {31'b0, mem_req}, 32'd0);

        // Following LW at 0xC completes normally.
        drive(1'b0, 1'b1, 3'b010, 32'h0000_000C, 32'h0);
        do_access(0, 32'hCAFE_F00D, stalls);
        chk("lw_data", DMDataRd_output, 32'hCAFE_F00D);
        chk("lw_stalls", stalls, 32'd3);

        // Store and load together: store wins.
        drive(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF);
        do_access(0, 32'h1111_1111, stalls);
        chk("both_we", {31'b0, mem_we}, 32'd1);
        chk("both_be", {28'b0, mem_be}, 32'hF);
        chk("both_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("both_addr", mem_addr, 32'h0000_0040);
        chk("both_rd_keep", DMDataRd_output, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
